// File: rtl/scan_if.sv
// Handshake and select bus between the scan controller (master) and scan_sequencer (slave).
// The SCAN_LOOP_EN macro adds the loop request and wrap indication signals.
interface scan_if #(
  parameter int unsigned DIV_W = 8
) ();
  logic             start;
  logic             stop;
  logic [3:0]       first;
  logic [3:0]       last;
  logic             up;
  logic [DIV_W-1:0] div;
  logic [3:0]       sel_out;
  logic             sel_valid;
  logic             busy;
  logic             step;
  logic             done;
`ifdef SCAN_LOOP_EN
  logic             loop;
  logic             wrap;
`endif

  modport master (
`ifdef SCAN_LOOP_EN
    output loop,
    input  wrap,
`endif
    output start, stop, first, last, up, div,
    input  sel_out, sel_valid, busy, step, done
  );

  modport slave (
`ifdef SCAN_LOOP_EN
    input  loop,
    output wrap,
`endif
    input  start, stop, first, last, up, div,
    output sel_out, sel_valid, busy, step, done
  );
endinterface

// File: rtl/scan_sequencer.sv
// Walks a latched index range (up/down, mod-16) holding each index div+1 cycles; drives decoder select.
// Optional continuous looping over the range is enabled by defining SCAN_LOOP_EN.
module scan_sequencer #(
  parameter int unsigned DIV_W = 8
) (
  input logic   clk,
  input logic   rst,
  scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [3:0]       first_q;
  logic [3:0]       last_q;
  logic             up_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre;
  logic [3:0]       sel_q;
  logic             sel_valid_q;
  logic             busy_q;
  logic             step_q;
  logic             done_q;
  logic             terminal_c;
`ifdef SCAN_LOOP_EN
  logic             loop_q;
  logic             wrap_q;
`endif

  // Last cycle of the current index dwell.
  assign terminal_c = (pre == div_q);

  // step is precomputed one cycle early so it is high exactly on the terminal dwell cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first_q     <= '0;
      last_q      <= '0;
      up_q        <= 1'b0;
      div_q       <= '0;
      pre         <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_LOOP_EN
      loop_q      <= 1'b0;
      wrap_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            first_q     <= bus.first;
            last_q      <= bus.last;
            up_q        <= bus.up;
            div_q       <= bus.div;
`ifdef SCAN_LOOP_EN
            loop_q      <= bus.loop;
`endif
            state       <= RUN;
            sel_q       <= bus.first;
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            pre         <= '0;
            step_q      <= (bus.div == '0);
          end
        end

        RUN: begin
`ifdef SCAN_LOOP_EN
          wrap_q <= 1'b0;
`endif
          pre <= terminal_c ? '0 : DIV_W'(pre + 1'b1);
          if (bus.stop) begin
            state       <= IDLE;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
          end else if (terminal_c) begin
            if (sel_q != last_q) begin
              sel_q  <= up_q ? 4'(sel_q + 4'd1) : 4'(sel_q - 4'd1);
              step_q <= (div_q == '0);
            end
`ifdef SCAN_LOOP_EN
            else if (loop_q) begin
              sel_q  <= first_q;
              wrap_q <= 1'b1;
              step_q <= (div_q == '0);
            end
`endif
            else begin
              state       <= DONE;
              done_q      <= 1'b1;
              sel_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              step_q      <= 1'b0;
            end
          end else begin
            step_q <= (DIV_W'(pre + 1'b1) == div_q);
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel_out   = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.step      = step_q;
  assign bus.done      = done_q;
`ifdef SCAN_LOOP_EN
  assign bus.wrap      = wrap_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; loop tests run when SCAN_LOOP_EN is defined.
module tb_scan_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  scan_if #(.DIV_W(8)) bus ();

  scan_sequencer #(.DIV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] sel);
    check({tag, "_sel"},   32'(bus.sel_out),   32'(sel));
    check({tag, "_valid"}, 32'(bus.sel_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_step"},  32'(bus.step),      32'd0);
    check({tag, "_done"},  32'(bus.done),      32'd0);
  endtask

  // Full single pass; len is the hand-computed number of indices.
  task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input logic u,
                          input logic [7:0] d, input int len);
    logic [3:0] e;
    bus.first = f; bus.last = l; bus.up = u; bus.div = d; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.first = ~f; bus.last = ~l; bus.up = ~u; bus.div = 8'(d + 8'd1);
    for (int k = 0; k < len; k++) begin
      e = u ? 4'(f + 4'(k)) : 4'(f - 4'(k));
      for (int c = 0; c <= int'(d); c++) begin
        check("run_sel",   32'(bus.sel_out),   32'(e));
        check("run_step",  32'(bus.step),      32'(c == int'(d)));
        check("run_busy",  32'(bus.busy),      32'd1);
        check("run_valid", 32'(bus.sel_valid), 32'd1);
        check("run_done",  32'(bus.done),      32'd0);
        cyc();
      end
    end
    check("end_done",  32'(bus.done),      32'd1);
    check("end_busy",  32'(bus.busy),      32'd0);
    check("end_valid", 32'(bus.sel_valid), 32'd0);
    check("end_sel",   32'(bus.sel_out),   32'(l));
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_idle("post_done", l);
    cyc();
    check_idle("no_queue", l);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.first = 4'd0; bus.last = 4'd0;
    bus.up = 1'b0; bus.div = 8'd0;
`ifdef SCAN_LOOP_EN
    bus.loop = 1'b0;
`endif
    cyc();
    cyc();
    rst = 1'b0;
    check_idle("reset", 4'd0);
    cyc();
    check_idle("idle_hold", 4'd0);

    run_scan(4'd2,  4'd5,  1'b1, 8'd0, 4);
    run_scan(4'd14, 4'd1,  1'b1, 8'd2, 4);
    run_scan(4'd1,  4'd14, 1'b0, 8'd0, 4);
    run_scan(4'd7,  4'd7,  1'b1, 8'd1, 1);

    // Abort at index 3 with div=3: indices 0..2 take 12 cycles.
    bus.first = 4'd0; bus.last = 4'd9; bus.up = 1'b1; bus.div = 8'd3; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (12) cyc();
    check("pre_stop_sel",  32'(bus.sel_out), 32'd3);
    check("pre_stop_step", 32'(bus.step),    32'd0);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_idle("stop", 4'd3);
    cyc();
    check_idle("stop_hold", 4'd3);

    // Restart with div=0, ignored mid-run start, then reset at index 6.
    bus.div = 8'd0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("restart_sel",  32'(bus.sel_out), 32'd0);
    check("restart_busy", 32'(bus.busy),    32'd1);
    check("restart_step", 32'(bus.step),    32'd1);
    cyc();
    cyc();
    bus.first = 4'd12; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("midstart_sel",  32'(bus.sel_out), 32'd3);
    check("midstart_busy", 32'(bus.busy),    32'd1);
    repeat (3) cyc();
    check("pre_rst_sel", 32'(bus.sel_out), 32'd6);
    rst = 1'b1;
    bus.start = 1'b1;
    cyc();
    rst = 1'b0;
    bus.start = 1'b0;
    check_idle("mid_rst", 4'd0);

    // Stop coinciding with a terminal cycle: step still seen, no advance.
    bus.first = 4'd0; bus.last = 4'd9; bus.div = 8'd0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    check("term_stop_sel",  32'(bus.sel_out), 32'd3);
    check("term_stop_step", 32'(bus.step),    32'd1);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_idle("term_stop", 4'd3);
    cyc();
    check_idle("term_stop_hold", 4'd3);

`ifdef SCAN_LOOP_EN
    bus.loop = 1'b1; bus.first = 4'd0; bus.last = 4'd2; bus.up = 1'b1; bus.div = 8'd0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("loop_sel",  32'(bus.sel_out), 32'(k % 3));
      check("loop_wrap", 32'(bus.wrap),    32'(k > 0 && (k % 3) == 0));
      check("loop_done", 32'(bus.done),    32'd0);
      check("loop_busy", 32'(bus.busy),    32'd1);
      cyc();
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    check_idle("loop_stop", 4'd0);
    check("loop_stop_wrap", 32'(bus.wrap), 32'd0);
    cyc();
    check_idle("loop_stop_hold", 4'd0);
    run_scan(4'd3, 4'd4, 1'b1, 8'd0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequential index generator driving the 4-bit select input of the 4x16 decoder (d_in); also usable as a select source for the 3x8 decoder via sel_out[2:0].
- Walks a programmable index range (first..last, up or down, mod-16 wrap) and holds each index for a programmable number of cycles.
- start/done handshake toward the controller; the decoder consumes sel_out combinationally.

Parameters:
- DIV_W, 8, width of the dwell-divider input and internal prescaler.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin scan; sampled only in IDLE
- stop  input  1  abort scan; sampled only in RUN
- first  input  4  first index, latched on accepted start
- last  input  4  final index, latched on accepted start
- up  input  1  1 = increment, 0 = decrement; latched on start
- div  input  DIV_W  dwell; each index held div+1 cycles; latched on start
- sel_out  output  4  current index, to decoder d_in
- sel_valid  output  1  sel_out is an active scan index
- busy  output  1  high in RUN
- step  output  1  one-cycle pulse on the last cycle of each index dwell
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE; sel_out=0, sel_valid=0, busy=0, step=0, done=0; prescaler=0; latched config=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch first/last/up/div; next cycle RUN, sel_out=first, sel_valid=1, busy=1, prescaler=0.
  - Otherwise hold; sel_out keeps its last value.
- RUN:
  - Prescaler counts 0..div_latched. Terminal cycle is prescaler==div_latched: step=1 that cycle; prescaler returns to 0.
  - Terminal with sel_out!=last: sel_out becomes sel_out+1 (up) or sel_out-1 (down), 4-bit modulo (15->0, 0->15).
  - Terminal with sel_out==last: next state DONE; sel_out holds.
  - div=0: new index every cycle; step high every RUN cycle.
- Scan length: ((last-first) mod 16)+1 indices when up; ((first-last) mod 16)+1 when down. first==last gives one index.
- Total RUN cycles: length*(div+1).
- DONE: lasts exactly 1 cycle; done=1, busy=0, sel_valid=0, sel_out=last; then IDLE. start during DONE is ignored, not queued.
- stop in RUN: next cycle IDLE; busy=0, sel_valid=0, no done, no further step; sel_out holds the current index.
- stop and terminal in the same cycle: the step pulse for that cycle still fires; stop wins for the next state, so the next state is IDLE with no done and no advance.
- start outside IDLE: ignored. Input changes to first/last/up/div during RUN: no effect.
- rst mid-operation: next edge restores all reset values regardless of state; it overrides start and stop.
- step, done, busy and sel_valid are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro SCAN_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit), latched on start, and output port wrap (1 bit).
  - With loop=1, a terminal step at sel_out==last reloads sel_out=first, pulses wrap for 1 cycle (coincident with the reload), and stays in RUN with no done. It continues until stop or rst.
  - With loop=0, behaviour is identical to the undefined case.
- Undefined: no loop or wrap ports; always a single pass ending in DONE.

Test Plan:
- Reset, then start with first=2, last=5, up=1, div=0 -> sel_out 2,3,4,5 on 4 consecutive cycles with sel_valid=1, busy=1 and step every cycle. Next cycle done=1, busy=0, sel_out=5. Following cycle IDLE.
- first=14, last=1, up=1, div=2 -> sel_out 14,15,0,1, each held 3 cycles. step fires on cycles 3,6,9,12 of RUN. done follows after 12 RUN cycles.
- first=1, last=14, up=0, div=0 -> sel_out 1,0,15,14, then done. first=last=7 -> single index 7 for div+1 cycles, then done.
- first=0, last=9, div=3; assert stop while sel_out=3 -> next cycle busy=0, sel_valid=0, done=0, sel_out=3. A start 2 cycles later is accepted and rescans from first.
- start pulsed mid-RUN -> ignored, scan unaffected. rst asserted mid-RUN at sel_out=6 -> next cycle all outputs at reset values (sel_out=0).
- With SCAN_LOOP_EN and loop=1, first=0, last=2, div=0 -> sel_out 0,1,2,0,1,2,... with wrap=1 on each return to 0 and done never asserted. stop ends in IDLE with no done.
